// File: rtl/exception_cause_ctrl_if.sv
// -----------------------------------------------------------------------------
// exception_cause_ctrl_if
// Bundles the exception-source requests and the control-unit handshake of the
// exception cause controller.
//   master : drives exc_req/exc_mask/pc_in (datapath detectors) and
//            exc_ack/eret (control FSM); observes the presented exception.
//   slave  : the controller itself.
// Signals:
//   exc_req     [NUM_SRC]  per-source request
//   exc_mask    [NUM_SRC]  1 = source disabled
//   pc_in       [CAUSE_W]  PC of the instruction raising a request this cycle
//   exc_ack                control unit accepts the presented exception
//   eret                   handler finished
//   exc_pending            exception presented, awaiting ack
//   in_handler             exception accepted, handler running
//   cause_code  [CAUSE_W]  CODE_BASE + src_id
//   epc         [CAUSE_W]  buffered PC of presented/serviced exception
//   src_id      [SRC_W]    index of presented/serviced source
//   lost_cnt    [LOST_W]   saturating count of merged requests
// -----------------------------------------------------------------------------
interface exception_cause_ctrl_if #(
   parameter int NUM_SRC = 3,
   parameter int CAUSE_W = 32,
   parameter int LOST_W  = 4
);
   localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   logic [NUM_SRC-1:0] exc_req;
   logic [NUM_SRC-1:0] exc_mask;
   logic [CAUSE_W-1:0] pc_in;
   logic               exc_ack;
   logic               eret;
   logic               exc_pending;
   logic               in_handler;
   logic [CAUSE_W-1:0] cause_code;
   logic [CAUSE_W-1:0] epc;
   logic [SRC_W-1:0]   src_id;
   logic [LOST_W-1:0]  lost_cnt;

   modport master (
      output exc_req, exc_mask, pc_in, exc_ack, eret,
      input  exc_pending, in_handler, cause_code, epc, src_id, lost_cnt
   );

   modport slave (
      input  exc_req, exc_mask, pc_in, exc_ack, eret,
      output exc_pending, in_handler, cause_code, epc, src_id, lost_cnt
   );
endinterface

// File: rtl/exception_cause_ctrl.sv
// -----------------------------------------------------------------------------
// exception_cause_ctrl
// Latches requests from NUM_SRC exception sources together with the faulting
// PC of each, arbitrates by fixed priority (lowest index wins) and presents a
// single cause code / EPC to the control unit with an ack/eret handshake.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous reset, active-low
//   bus    exception_cause_ctrl_if.slave (requests in, presented exception out)
// -----------------------------------------------------------------------------
module exception_cause_ctrl #(
   parameter int NUM_SRC   = 3,
   parameter int CODE_BASE = 253,
   parameter int CAUSE_W   = 32,
   parameter int LOST_W    = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   exception_cause_ctrl_if.slave bus
);
   localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam logic [LOST_W-1:0] LOST_MAX = {LOST_W{1'b1}};

   typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_SVC} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [NUM_SRC-1:0] r_pend;
   logic [CAUSE_W-1:0] r_slot [NUM_SRC];
   logic [SRC_W-1:0]   r_src_id;
   logic [CAUSE_W-1:0] r_cause;
   logic [CAUSE_W-1:0] r_epc;
   logic [LOST_W-1:0]  r_lost;

   logic [NUM_SRC-1:0] w_req_eff;
   logic [NUM_SRC-1:0] w_clr;
   logic [NUM_SRC-1:0] w_pend_kept;
   logic [NUM_SRC-1:0] w_load;
   logic [NUM_SRC-1:0] w_merge;
   logic [SRC_W-1:0]   w_sel;
   logic               w_accept;
   logic               w_present;
   logic               w_pending;
   logic               w_handler;

   // Lowest set index of the pending vector.
   function automatic logic [SRC_W-1:0] prio_sel(input logic [NUM_SRC-1:0] p);
      logic [SRC_W-1:0] s;
      s = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (p[i]) s = SRC_W'(i);
      end
      return s;
   endfunction

   // Adds one per merged source, sticking at the counter maximum.
   function automatic logic [LOST_W-1:0] lost_add(input logic [LOST_W-1:0] cnt,
                                                  input logic [NUM_SRC-1:0] merged);
      logic [LOST_W-1:0] c;
      c = cnt;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (merged[i] && (c != LOST_MAX)) c = c + LOST_W'(1);
      end
      return c;
   endfunction

   assign w_req_eff   = bus.exc_req & ~bus.exc_mask;
   assign w_accept    = (r_state == ST_PEND) && bus.exc_ack;
   assign w_clr       = w_accept ? (NUM_SRC'(1) << r_src_id) : '0;
   // Clearing first means a same-edge request on the accepted source is a
   // fresh latch (new PC) rather than a merge.
   assign w_pend_kept = r_pend & ~w_clr;
   assign w_load      = w_req_eff & ~w_pend_kept;
   assign w_merge     = w_req_eff & w_pend_kept;
   assign w_sel       = prio_sel(r_pend);

   always_ff @(posedge clk) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_present   = 1'b0;
      w_pending   = 1'b0;
      w_handler   = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            // Arbitration looks only at already-latched requests.
            if (|r_pend) begin
               w_present   = 1'b1;
               w_state_nxt = ST_PEND;
            end
         end
         ST_PEND: begin
            w_pending = 1'b1;
            if (bus.exc_ack) w_state_nxt = ST_SVC;
         end
         ST_SVC: begin
            w_handler = 1'b1;
            if (bus.eret) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_pend   <= '0;
         r_lost   <= '0;
         r_src_id <= '0;
         r_cause  <= '0;
         r_epc    <= '0;
         for (int i = 0; i < NUM_SRC; i++) r_slot[i] <= '0;
      end else begin
         r_pend <= w_pend_kept | w_req_eff;
         r_lost <= lost_add(r_lost, w_merge);
         // Slot is only written on a fresh latch so the oldest PC survives merges.
         for (int i = 0; i < NUM_SRC; i++) begin
            if (w_load[i]) r_slot[i] <= bus.pc_in;
         end
         if (w_present) begin
            r_src_id <= w_sel;
            r_cause  <= CAUSE_W'(CODE_BASE) + CAUSE_W'(w_sel);
            r_epc    <= r_slot[w_sel];
         end
      end
   end

   assign bus.exc_pending = w_pending;
   assign bus.in_handler  = w_handler;
   assign bus.cause_code  = r_cause;
   assign bus.epc         = r_epc;
   assign bus.src_id      = r_src_id;
   assign bus.lost_cnt    = r_lost;
endmodule

// File: tb/tb_exception_cause_ctrl.sv
// -----------------------------------------------------------------------------
// tb_exception_cause_ctrl
// Self-checking bench for exception_cause_ctrl (LOST_W=2 so saturation is
// reachable quickly). A behavioural model tracks pending sources, PC slots,
// the presentation mode and the lost counter.
// -----------------------------------------------------------------------------
module tb_exception_cause_ctrl;
   localparam int NUM_SRC   = 3;
   localparam int CODE_BASE = 253;
   localparam int CAUSE_W   = 32;
   localparam int LOST_W    = 2;
   localparam int SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int LOST_MAX  = (1 << LOST_W) - 1;
   localparam int VW        = 2 + SRC_W + 2 * CAUSE_W + LOST_W;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   exception_cause_ctrl_if #(.NUM_SRC(NUM_SRC), .CAUSE_W(CAUSE_W), .LOST_W(LOST_W)) bus ();

   exception_cause_ctrl #(
      .NUM_SRC(NUM_SRC), .CODE_BASE(CODE_BASE), .CAUSE_W(CAUSE_W), .LOST_W(LOST_W)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   // ---------------- reference model ----------------
   bit                 m_pend [NUM_SRC];
   logic [CAUSE_W-1:0] m_slot [NUM_SRC];
   int                 m_mode = 0;   // 0 idle, 1 presenting, 2 in handler
   int                 m_src  = 0;
   logic [CAUSE_W-1:0] m_cause = '0;
   logic [CAUSE_W-1:0] m_epc   = '0;
   int                 m_lost  = 0;

   task automatic model_step();
      logic [NUM_SRC-1:0] req;
      bit accept;
      int acc_src;
      int first;
      if (reset === 1'b0) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            m_pend[i] = 0;
            m_slot[i] = '0;
         end
         m_mode = 0; m_src = 0; m_cause = '0; m_epc = '0; m_lost = 0;
      end else begin
         req     = bus.exc_req & ~bus.exc_mask;
         accept  = (m_mode == 1) && (bus.exc_ack === 1'b1);
         acc_src = m_src;
         case (m_mode)
            0: begin
               first = -1;
               for (int i = NUM_SRC - 1; i >= 0; i--) if (m_pend[i]) first = i;
               if (first >= 0) begin
                  m_src   = first;
                  m_cause = CAUSE_W'(CODE_BASE + first);
                  m_epc   = m_slot[first];
                  m_mode  = 1;
               end
            end
            1: if (bus.exc_ack === 1'b1) m_mode = 2;
            default: if (bus.eret === 1'b1) m_mode = 0;
         endcase
         if (accept) m_pend[acc_src] = 0;
         for (int i = 0; i < NUM_SRC; i++) begin
            if (req[i]) begin
               if (!m_pend[i]) begin
                  m_pend[i] = 1;
                  m_slot[i] = bus.pc_in;
               end else begin
                  m_lost = (m_lost < LOST_MAX) ? m_lost + 1 : LOST_MAX;
               end
            end
         end
      end
   endtask

   function automatic logic [VW-1:0] exp_vec();
      return {m_mode == 1, m_mode == 2, SRC_W'(m_src), m_cause, m_epc, LOST_W'(m_lost)};
   endfunction

   function automatic logic [VW-1:0] obs_vec();
      return {bus.exc_pending, bus.in_handler, bus.src_id, bus.cause_code, bus.epc, bus.lost_cnt};
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic set_in(input logic [NUM_SRC-1:0] req, input logic [NUM_SRC-1:0] mask,
                         input logic [CAUSE_W-1:0] pc, input logic ack, input logic er);
      bus.exc_req  = req;
      bus.exc_mask = mask;
      bus.pc_in    = pc;
      bus.exc_ack  = ack;
      bus.eret     = er;
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      set_in('0, '0, '0, 1'b0, 1'b0);
      reset = 1'b0;
      cycle();
      reset = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         set_in(NUM_SRC'($urandom), NUM_SRC'($urandom), $urandom, 1'($urandom), 1'($urandom));
         cycle();
      end
      checks++;
      if (obs_vec() !== '0) $display("FAIL reset_hold: got %h want 0", obs_vec());
      else passed++;
      reset = 1'b1;
      set_in('0, '0, '0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         cycle();
         checks++;
         if (obs_vec() !== exp_vec() || obs_vec() !== '0)
            $display("FAIL reset_release: got %h want %h", obs_vec(), exp_vec());
         else passed++;
      end
   endtask

   task automatic test_single();
      set_in(3'b010, '0, 32'h40, 1'b0, 1'b0);
      cycle();
      set_in('0, '0, '0, 1'b0, 1'b0);
      checks++;
      if (bus.exc_pending !== 1'b0) $display("FAIL single_latency: pending %b want 0", bus.exc_pending);
      else passed++;
      cycle();
      checks++;
      if ({bus.exc_pending, bus.in_handler, bus.cause_code, bus.epc, bus.src_id} !==
          {1'b1, 1'b0, 32'd254, 32'h40, SRC_W'(1)})
         $display("FAIL single_present: got p=%b c=%0d epc=%h id=%0d want p=1 c=254 epc=40 id=1",
                  bus.exc_pending, bus.cause_code, bus.epc, bus.src_id);
      else passed++;
      set_in('0, '0, '0, 1'b1, 1'b0);
      cycle();
      set_in('0, '0, '0, 1'b0, 1'b0);
      checks++;
      if ({bus.exc_pending, bus.in_handler, bus.cause_code, bus.epc} !== {1'b0, 1'b1, 32'd254, 32'h40})
         $display("FAIL single_svc: got p=%b h=%b c=%0d epc=%h want p=0 h=1 c=254 epc=40",
                  bus.exc_pending, bus.in_handler, bus.cause_code, bus.epc);
      else passed++;
      set_in('0, '0, '0, 1'b0, 1'b1);
      cycle();
      set_in('0, '0, '0, 1'b0, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec() || bus.exc_pending !== 1'b0 || bus.in_handler !== 1'b0)
         $display("FAIL single_eret: got %h want %h", obs_vec(), exp_vec());
      else passed++;
   endtask

   task automatic test_priority();
      set_in(3'b101, '0, 32'h10, 1'b0, 1'b0);
      cycle();
      set_in('0, '0, '0, 1'b0, 1'b0);
      cycle();
      checks++;
      if ({bus.exc_pending, bus.cause_code, bus.epc, bus.src_id} !== {1'b1, 32'd253, 32'h10, SRC_W'(0)})
         $display("FAIL prio_first: got c=%0d epc=%h id=%0d want c=253 epc=10 id=0",
                  bus.cause_code, bus.epc, bus.src_id);
      else passed++;
      set_in('0, '0, '0, 1'b1, 1'b0); cycle();
      set_in('0, '0, '0, 1'b0, 1'b1); cycle();
      set_in('0, '0, '0, 1'b0, 1'b0);
      checks++;
      if (bus.exc_pending !== 1'b0 || obs_vec() !== exp_vec())
         $display("FAIL prio_idle_gap: got %h want %h", obs_vec(), exp_vec());
      else passed++;
      cycle();
      checks++;
      if ({bus.exc_pending, bus.cause_code, bus.epc, bus.src_id} !== {1'b1, 32'd255, 32'h10, SRC_W'(2)})
         $display("FAIL prio_second: got c=%0d epc=%h id=%0d want c=255 epc=10 id=2",
                  bus.cause_code, bus.epc, bus.src_id);
      else passed++;
      set_in('0, '0, '0, 1'b1, 1'b0); cycle();
      set_in('0, '0, '0, 1'b0, 1'b1); cycle();
      set_in('0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic test_mask();
      do_reset();
      set_in(3'b100, 3'b100, 32'h99, 1'b0, 1'b0);
      cycle();
      set_in('0, '0, '0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         cycle();
         checks++;
         if (bus.exc_pending !== 1'b0 || bus.lost_cnt !== '0 || obs_vec() !== exp_vec())
            $display("FAIL mask_ignored: got p=%b lost=%0d want p=0 lost=0",
                     bus.exc_pending, bus.lost_cnt);
         else passed++;
      end
   endtask

   task automatic test_lost_saturation();
      do_reset();
      set_in(3'b100, '0, 32'h20, 1'b0, 1'b0);
      cycle();
      for (int k = 1; k <= 4; k++) begin
         set_in(3'b100, '0, CAUSE_W'(32'h20 + 4 * k), 1'b0, 1'b0);
         cycle();
      end
      set_in('0, '0, '0, 1'b0, 1'b0);
      cycle();
      checks++;
      if ({bus.exc_pending, bus.epc, bus.lost_cnt, bus.cause_code} !== {1'b1, 32'h20, 2'd3, 32'd255})
         $display("FAIL lost_sat: got p=%b epc=%h lost=%0d c=%0d want p=1 epc=20 lost=3 c=255",
                  bus.exc_pending, bus.epc, bus.lost_cnt, bus.cause_code);
      else passed++;
      set_in('0, '0, '0, 1'b1, 1'b0); cycle();
      set_in('0, '0, '0, 1'b0, 1'b1); cycle();
      set_in('0, '0, '0, 1'b0, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec() || bus.lost_cnt !== 2'd3)
         $display("FAIL lost_hold: got %h want %h", obs_vec(), exp_vec());
      else passed++;
   endtask

   task automatic test_back_to_back();
      do_reset();
      set_in(3'b001, '0, 32'h44, 1'b0, 1'b0); cycle();
      set_in('0, '0, '0, 1'b0, 1'b0);          cycle();
      set_in(3'b001, '0, 32'h50, 1'b1, 1'b0); cycle();
      set_in('0, '0, '0, 1'b0, 1'b0);
      checks++;
      if ({bus.in_handler, bus.exc_pending, bus.epc, bus.lost_cnt} !== {1'b1, 1'b0, 32'h44, 2'd0})
         $display("FAIL b2b_svc: got h=%b p=%b epc=%h lost=%0d want h=1 p=0 epc=44 lost=0",
                  bus.in_handler, bus.exc_pending, bus.epc, bus.lost_cnt);
      else passed++;
      set_in('0, '0, '0, 1'b0, 1'b1); cycle();
      set_in('0, '0, '0, 1'b0, 1'b0); cycle();
      checks++;
      if ({bus.exc_pending, bus.cause_code, bus.epc} !== {1'b1, 32'd253, 32'h50})
         $display("FAIL b2b_repres: got p=%b c=%0d epc=%h want p=1 c=253 epc=50",
                  bus.exc_pending, bus.cause_code, bus.epc);
      else passed++;
      set_in('0, '0, '0, 1'b1, 1'b0);          cycle();
      set_in(3'b010, '0, 32'h60, 1'b0, 1'b0); cycle();
      set_in('0, '0, '0, 1'b0, 1'b0);
      reset = 1'b0;
      cycle();
      checks++;
      if (obs_vec() !== '0) $display("FAIL svc_reset: got %h want 0", obs_vec());
      else passed++;
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cycle();
         checks++;
         if (bus.exc_pending !== 1'b0 || obs_vec() !== exp_vec())
            $display("FAIL svc_reset_stale: got %h want %h", obs_vec(), exp_vec());
         else passed++;
      end
   endtask

   task automatic test_random();
      int bad;
      bad = 0;
      do_reset();
      for (int k = 0; k < 600; k++) begin
         set_in(($urandom_range(0, 2) == 0) ? NUM_SRC'($urandom) : '0,
                ($urandom_range(0, 4) == 0) ? NUM_SRC'($urandom) : '0,
                $urandom,
                1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 2) == 0));
         reset = ($urandom_range(0, 99) != 0);
         cycle();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            if (bad < 10)
               $display("FAIL random_cycle%0d: got %h want %h", k, obs_vec(), exp_vec());
            bad++;
         end else passed++;
      end
      reset = 1'b1;
      set_in('0, '0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      set_in('0, '0, '0, 1'b0, 1'b0);
      test_reset();
      test_single();
      test_priority();
      test_mask();
      test_lost_saturation();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
